activation_unit: RTL and testbench
==================================

Name: activation_unit

Overview:
Single-cycle, registered INT8 activation stage for the accelerator datapath. It takes a signed 16-bit accumulator value, applies a selectable activation function (ReLU, hard tanh, piecewise-linear sigmoid, or saturating pass-through), and produces a signed 8-bit result with a valid strobe. It sits between the MAC/accumulator output and the INT8 result writeback.

Parameters:
None. Widths are fixed: 16-bit input, 8-bit output.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
activation_type  input  2  00=ReLU, 01=tanh, 10=sigmoid, 11=none (pass-through)
enable  input  1  request strobe; data_in and activation_type are sampled on the rising edge where it is high
data_in  input  16  signed two's-complement pre-activation value
data_out  output  8  signed two's-complement activation result
valid  output  1  one-cycle pulse marking a new data_out

Behaviour:
- Reset: the design uses one clock (clk) and an asynchronous, active-low reset (rst_n).
  - While rst_n=0: data_out=0, valid=0, independent of clk.
- Latency: 1 cycle.
  - On a rising edge with enable=1: data_out <= f(activation_type, data_in) and valid <= 1.
  - On a rising edge with enable=0: valid <= 0 and data_out holds its last value.
- Throughput: one result per cycle.
  - Back-to-back enables give valid high on consecutive cycles, each with its own result.
- No internal state beyond the output registers. activation_type may change on every request.
- Functions (x = signed 16-bit data_in):
  - ReLU (00): x<=0 -> 0; 0<x<=127 -> x; x>127 -> 127.
  - tanh (01): hard tanh, where Q1.6 has 64 = 1.0.
    - x < -64 -> -64.
    - -64<=x<=64 -> x.
    - x > 64 -> 64.
  - sigmoid (10): piecewise linear, where 64 = 0.5 and 128 = 1.0.
    - Let a = |x|, computed in 17 bits so that -32768 is handled.
    - g(a) = 64 + (a>>2) for a<128.
    - g(a) = 96 + ((a-128)>>1) for 128<=a<192.
    - g(a) = 128 for a>=192.
    - x>=0 -> min(g(a),127); x<0 -> 128 - g(a).
    - Result is always in 0..127.
  - none (11): saturate x to -128..127.
- Arithmetic: all comparisons are signed and performed at 16+ bits before truncation. There is no wrap-around.
  - Boundary values must follow the definitions above: 127/128, -128/-129, 64/65, and the extremes 32767 and -32768.
- Reset mid-operation: asserting rst_n clears valid and data_out immediately, and any pending request is dropped.
- An enable coincident with reset deassertion is ignored unless rst_n is already high at that edge.

Test Plan:
- ReLU: inputs 50, -50, 0, 200, -200 -> outputs 50, 0, 0, 127, 0.
  - Each result arrives with a one-cycle valid pulse, 1 cycle after enable.
- tanh: inputs 0, 32, -32, 100, -100 -> outputs 0, 32, -32, 64, -64.
  - Also 64 -> 64 and 65 -> 64.
- Sigmoid: inputs 0, 64, -64, 200, -200 -> outputs 64, 80, 48, 127, 0.
  - Also 128 -> 96, -128 -> 32, 32767 -> 127, -32768 -> 0.
- None: inputs 50, -50, 200, -200 -> outputs 50, -50, 127, -128.
  - Also 127 -> 127, -128 -> -128, -129 -> -128.
- Handshake: enable pulsed for 1 cycle -> valid high for exactly one cycle.
  - data_out holds after valid drops.
  - 3 back-to-back enables with different types/inputs -> 3 consecutive valid cycles with the correct results.
- Reset: assert rst_n low asynchronously while valid=1 -> data_out=0 and valid=0 immediately, without waiting for a clock edge.
  - After release, the next enable produces a correct result.

Source files
------------

// File: rtl/activation_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : activation_if                                                    |
// | Brief   : Request/result bundle between the accumulator and activation unit|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface activation_if;
  logic        enable;
  logic [1:0]  activation_type;
  logic [15:0] data_in;
  logic [7:0]  data_out;
  logic        valid;

  modport master (
    output enable,
    output activation_type,
    output data_in,
    input  data_out,
    input  valid
  );

  modport slave (
    input  enable,
    input  activation_type,
    input  data_in,
    output data_out,
    output valid
  );
endinterface
`default_nettype wire

// File: rtl/activation_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : activation_unit                                                  |
// | Brief   : Registered INT8 activation (ReLU / hard tanh / PWL sigmoid /     |
// |           saturating pass-through) of a signed 16-bit accumulator value    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module activation_unit (
  input  wire logic    clk,
  input  wire logic    rst_n,
  activation_if.slave  bus
);

  localparam logic [1:0] c_ACT_RELU = 2'b00;
  localparam logic [1:0] c_ACT_TANH = 2'b01;
  localparam logic [1:0] c_ACT_SIGM = 2'b10;
  localparam logic [1:0] c_ACT_NONE = 2'b11;

  logic signed [15:0] w_x;
  logic        [16:0] w_abs;
  logic        [7:0]  w_sig_g;
  logic        [7:0]  w_sig;
  logic        [7:0]  w_result;
  logic        [7:0]  r_data;
  logic               r_valid;

  assign w_x = bus.data_in;

  // Magnitude in 17 bits so that -32768 maps to +32768 rather than wrapping.
  assign w_abs = w_x[15] ? (17'd0 - {w_x[15], w_x}) : {1'b0, w_x};

  always_comb begin
    w_sig_g = 8'd128;
    if (w_abs < 17'd128) begin
      w_sig_g = 8'd64 + {3'b000, w_abs[6:2]};
    end else if (w_abs < 17'd192) begin
      w_sig_g = 8'd96 + {3'b000, w_abs[5:1]};
    end
  end

  // Negative side mirrors around 0.5 (64); positive side clips 1.0 to 127.
  always_comb begin
    w_sig = 8'd0;
    if (w_x[15]) begin
      w_sig = 8'd128 - w_sig_g;
    end else if (w_sig_g == 8'd128) begin
      w_sig = 8'd127;
    end else begin
      w_sig = w_sig_g;
    end
  end

  always_comb begin
    w_result = w_x[7:0];
    case (bus.activation_type)
      c_ACT_RELU: begin
        if (w_x <= 16'sd0)        w_result = 8'd0;
        else if (w_x > 16'sd127)  w_result = 8'd127;
      end
      c_ACT_TANH: begin
        if (w_x < -16'sd64)       w_result = 8'hC0;
        else if (w_x > 16'sd64)   w_result = 8'd64;
      end
      c_ACT_SIGM: begin
        w_result = w_sig;
      end
      c_ACT_NONE: begin
        if (w_x < -16'sd128)      w_result = 8'h80;
        else if (w_x > 16'sd127)  w_result = 8'd127;
      end
      default: begin
        w_result = w_x[7:0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= 8'd0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= bus.enable;
      if (bus.enable) begin
        r_data <= w_result;
      end
    end
  end

  assign bus.data_out = r_data;
  assign bus.valid    = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_activation_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_activation_unit                                               |
// | Brief   : Scoreboard bench for activation_unit with directed vectors       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_activation_unit;

  typedef struct {
    logic [1:0]  t;
    logic [15:0] x;
    logic [7:0]  e;
  } vec_t;

  logic clk;
  logic rst_n;
  activation_if bus ();

  activation_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_pass;
  int          n_total;
  logic [7:0]  exp_q[$];
  vec_t        vecs[$];
  logic [7:0]  held;

  task automatic add(input logic [1:0] t, input int x, input int e);
    vec_t v;
    v.t = t;
    v.x = 16'(x);
    v.e = 8'(e);
    vecs.push_back(v);
  endtask

  // Issues every queued vector back-to-back, then drops enable.
  task automatic run_vecs();
    foreach (vecs[i]) begin
      @(negedge clk);
      bus.enable          = 1'b1;
      bus.activation_type = vecs[i].t;
      bus.data_in         = vecs[i].x;
      exp_q.push_back(vecs[i].e);
    end
    @(negedge clk);
    bus.enable = 1'b0;
    vecs.delete();
  endtask

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    n_pass              = 0;
    n_total             = 0;
    rst_n               = 1'b0;
    bus.enable          = 1'b0;
    bus.activation_type = 2'b00;
    bus.data_in         = 16'd0;

    #3;
    check("reset_data_out", int'(bus.data_out), 0);
    check("reset_valid", int'(bus.valid), 0);

    fork
      forever begin
        logic [7:0] e;
        @(negedge clk);
        if (rst_n && bus.valid) begin
          n_total++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_valid: got valid=1 data=%0d, expected no result",
                     $signed(bus.data_out));
          end else begin
            e = exp_q.pop_front();
            if (bus.data_out === e) n_pass++;
            else $display("FAIL result: got %0d, expected %0d",
                          $signed(bus.data_out), $signed(e));
          end
        end
      end
    join_none

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ReLU
    add(2'b00, 50, 50);  add(2'b00, -50, 0);  add(2'b00, 0, 0);
    add(2'b00, 200, 127); add(2'b00, -200, 0);
    run_vecs();
    // hard tanh
    add(2'b01, 0, 0);    add(2'b01, 32, 32);   add(2'b01, -32, -32);
    add(2'b01, 100, 64); add(2'b01, -100, -64); add(2'b01, 64, 64);
    add(2'b01, 65, 64);
    run_vecs();
    // sigmoid
    add(2'b10, 0, 64);    add(2'b10, 64, 80);    add(2'b10, -64, 48);
    add(2'b10, 200, 127); add(2'b10, -200, 0);   add(2'b10, 128, 96);
    add(2'b10, -128, 32); add(2'b10, 32767, 127); add(2'b10, -32768, 0);
    run_vecs();
    // saturating pass-through
    add(2'b11, 50, 50);   add(2'b11, -50, -50);  add(2'b11, 200, 127);
    add(2'b11, -200, -128); add(2'b11, 127, 127); add(2'b11, -128, -128);
    add(2'b11, -129, -128);
    run_vecs();
    // mixed types back-to-back
    add(2'b00, 300, 127); add(2'b10, -64, 48); add(2'b11, -300, -128);
    run_vecs();
    drain("drain_vectors");

    // Single pulse: valid for one cycle, data then holds.
    @(negedge clk);
    bus.enable          = 1'b1;
    bus.activation_type = 2'b11;
    bus.data_in         = 16'd42;
    exp_q.push_back(8'd42);
    @(negedge clk);
    bus.enable = 1'b0;
    check("pulse_valid_high", int'(bus.valid), 1);
    held = bus.data_out;
    @(negedge clk);
    check("pulse_valid_low", int'(bus.valid), 0);
    check("hold_data_out", int'($signed(bus.data_out)), 42);
    @(negedge clk);
    check("hold_valid_low", int'(bus.valid), 0);
    check("hold_data_again", int'(bus.data_out), int'(held));

    // Asynchronous reset while valid is high.
    @(negedge clk);
    bus.enable          = 1'b1;
    bus.activation_type = 2'b11;
    bus.data_in         = 16'd77;
    exp_q.push_back(8'd77);
    @(posedge clk);
    #1;
    check("pre_reset_valid", int'(bus.valid), 1);
    #1;
    rst_n      = 1'b0;
    bus.enable = 1'b0;
    #1;
    check("async_reset_data", int'(bus.data_out), 0);
    check("async_reset_valid", int'(bus.valid), 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    add(2'b01, -100, -64);
    run_vecs();
    drain("drain_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
